// File: rtl/fifo_rd_sequencer.sv
// -----------------------------------------------------------------------------
// fifo_rd_sequencer
//
// Read-side engine for the FIFO bring-up bench. Waits for the writer to report
// fill-done, then drains NUM_READS words from the FIFO. It can drain back-to-back
// (burst) or with pseudo-random gaps taken from an 8-bit LFSR. Every popped word
// is checked against an incrementing pattern. It reports read-done and a
// saturating mismatch count so a phase controller can move on.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   run request (level), sampled in IDLE
//   mode        in   0 = burst, 1 = random-gap; latched when a run starts
//   fill_done   in   writer has finished filling (level)
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   FIFO read data, valid one cycle after rd_en
//   rd_en       out  FIFO pop strobe
//   busy        out  high in WAIT_FILL / READ / FLUSH
//   read_done   out  high in DONE
//   err         out  sticky mismatch flag
//   err_count   out  mismatch count, saturates at 8'hFF
// -----------------------------------------------------------------------------
module fifo_rd_sequencer #(
    parameter int           DATA_WIDTH = 4,
    parameter int           NUM_READS  = 8,
    parameter logic [7:0]   LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  fill_done,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  rd_en,
    output logic                  busy,
    output logic                  read_done,
    output logic                  err,
    output logic [7:0]            err_count
);

    localparam int CNT_W = $clog2(NUM_READS + 1);
    localparam logic [CNT_W-1:0] LAST_POP = CNT_W'(NUM_READS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FILL,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic                    mode_q;
    logic [CNT_W-1:0]        rd_cnt_q;
    logic [7:0]              lfsr_q;
    logic [7:0]              lfsr_d;
    logic                    chk_vld_q;
    logic [DATA_WIDTH-1:0]   exp_data_q;
    logic                    err_q;
    logic [7:0]              err_count_q;
    logic                    busy_q;
    logic                    read_done_q;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left; the newest bit lands in
    // bit 0, which gates pops in random-gap mode.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Decoded only from registered state and the live empty flag, so a pop can
    // never be issued against an empty FIFO.
    assign rd_en = (state_q == S_READ) && !fifo_empty && (!mode_q || lfsr_q[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            rd_cnt_q    <= '0;
            lfsr_q      <= LFSR_SEED;
            chk_vld_q   <= 1'b0;
            exp_data_q  <= '0;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
            busy_q      <= 1'b0;
            read_done_q <= 1'b0;
        end else begin
            if (state_q == S_READ) begin
                lfsr_q <= lfsr_d;
            end

            if (rd_en) begin
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end

            // Data for a pop arrives one cycle later; compare it then.
            chk_vld_q <= rd_en;
            if (chk_vld_q) begin
                exp_data_q <= exp_data_q + DATA_WIDTH'(1);
                if (fifo_rdata != exp_data_q) begin
                    err_q <= 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_WAIT_FILL;
                        mode_q   <= mode;
                        rd_cnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_WAIT_FILL: begin
                    if (fill_done) begin
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_en && (rd_cnt_q == LAST_POP)) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Last popped word is compared during this cycle.
                    state_q     <= S_DONE;
                    busy_q      <= 1'b0;
                    read_done_q <= 1'b1;
                end
                S_DONE: begin
                    if (!start) begin
                        state_q     <= S_IDLE;
                        read_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    read_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign read_done = read_done_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
